// File: rtl/register_access_master.sv
// Command-driven initiator for the register file: sequences single/burst writes and reads
// and returns read beats over a valid/ready response channel.
module register_access_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wdata_valid,
  output logic                  wdata_ready,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_load_addr,
  output logic [DATA_WIDTH-1:0] rf_data_in,
  output logic                  rf_store,
  output logic [ADDR_WIDTH-1:0] rf_store_addr,
  input  logic [DATA_WIDTH-1:0] rf_data_out
);

  localparam logic [2:0] IDLE       = 3'd0;
  localparam logic [2:0] WR_BEAT    = 3'd1;
  localparam logic [2:0] RD_ISSUE   = 3'd2;
  localparam logic [2:0] RD_CAPTURE = 3'd3;
  localparam logic [2:0] RD_HOLD    = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [LEN_WIDTH-1:0]  CNT_ONE  = 1;

  logic [2:0]            state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  cnt_reg, cnt_next;
  logic                  done_reg, done_next;
  logic [DATA_WIDTH-1:0] rsp_data_reg, rsp_data_next;
  // Last values presented to the file, so the address/data outputs hold outside their states.
  logic [ADDR_WIDTH-1:0] load_addr_reg, load_addr_next;
  logic [DATA_WIDTH-1:0] load_data_reg, load_data_next;
  logic [ADDR_WIDTH-1:0] store_addr_reg, store_addr_next;

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    cnt_next        = cnt_reg;
    done_next       = 1'b0;
    rsp_data_next   = rsp_data_reg;
    load_addr_next  = load_addr_reg;
    load_data_next  = load_data_reg;
    store_addr_next = store_addr_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          addr_next  = cmd_addr;
          cnt_next   = cmd_len;
          state_next = cmd_write ? WR_BEAT : RD_ISSUE;
        end
      end
      WR_BEAT: begin
        load_addr_next = addr_reg;
        load_data_next = wdata;
        if (wdata_valid) begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            addr_next = addr_reg + ADDR_ONE;
            cnt_next  = cnt_reg - CNT_ONE;
          end
        end
      end
      RD_ISSUE: begin
        store_addr_next = addr_reg;
        state_next      = RD_CAPTURE;
      end
      RD_CAPTURE: begin
        rsp_data_next = rf_data_out;
        state_next    = RD_HOLD;
      end
      RD_HOLD: begin
        if (rsp_ready) begin
          if (cnt_reg == '0) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            addr_next  = addr_reg + ADDR_ONE;
            cnt_next   = cnt_reg - CNT_ONE;
            state_next = RD_ISSUE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      cnt_reg        <= '0;
      done_reg       <= 1'b0;
      rsp_data_reg   <= '0;
      load_addr_reg  <= '0;
      load_data_reg  <= '0;
      store_addr_reg <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      cnt_reg        <= cnt_next;
      done_reg       <= done_next;
      rsp_data_reg   <= rsp_data_next;
      load_addr_reg  <= load_addr_next;
      load_data_reg  <= load_data_next;
      store_addr_reg <= store_addr_next;
    end
  end

  // Handshake and strobe outputs are forced low while reset is high, even before the edge.
  assign cmd_ready     = !reset && (state_reg == IDLE);
  assign wdata_ready   = !reset && (state_reg == WR_BEAT);
  assign rsp_valid     = !reset && (state_reg == RD_HOLD);
  assign busy          = !reset && (state_reg != IDLE);
  assign done          = !reset && done_reg;
  assign rf_load       = wdata_ready && wdata_valid;
  assign rf_store      = !reset && (state_reg == RD_ISSUE);
  assign rsp_data      = rsp_data_reg;
  assign rf_load_addr  = (state_reg == WR_BEAT) ? addr_reg : load_addr_reg;
  assign rf_data_in    = (state_reg == WR_BEAT) ? wdata : load_data_reg;
  assign rf_store_addr = (state_reg == RD_ISSUE) ? addr_reg : store_addr_reg;

endmodule

// File: tb/tb_register_access_master.sv
// Directed bench for register_access_master with a behavioural 16x8 register file attached.
module tb_register_access_master;

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [3:0] cmd_addr, cmd_len;
  logic       wdata_valid, wdata_ready;
  logic [7:0] wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       busy, done;
  logic       rf_load, rf_store;
  logic [3:0] rf_load_addr, rf_store_addr;
  logic [7:0] rf_data_in, rf_data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mem [16];
  logic [3:0] load_addr_q [$];
  logic [7:0] load_data_q [$];
  int store_cnt   = 0;
  int done_cnt    = 0;
  int overlap_cnt = 0;

  always #5 clock = ~clock;

  register_access_master dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .done(done),
    .rf_load(rf_load), .rf_load_addr(rf_load_addr), .rf_data_in(rf_data_in),
    .rf_store(rf_store), .rf_store_addr(rf_store_addr), .rf_data_out(rf_data_out)
  );

  // Register file model plus strobe/done logging.
  always @(posedge clock) begin
    if (rf_load) begin
      mem[rf_load_addr] <= rf_data_in;
      load_addr_q.push_back(rf_load_addr);
      load_data_q.push_back(rf_data_in);
    end
    if (rf_store) begin
      rf_data_out <= mem[rf_store_addr];
      store_cnt++;
    end
    if (done) done_cnt++;
    if (rf_load && rf_store) overlap_cnt++;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs;
    load_addr_q.delete();
    load_data_q.delete();
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if ({cmd_ready, wdata_ready, rsp_valid, busy, done, rf_load, rf_store} !== 7'b0) begin n_fail++; $display("FAIL reset_outputs: got %b required 0000000", {cmd_ready, wdata_ready, rsp_valid, busy, done, rf_load, rf_store}); end
    end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_data: got %h required 00", rsp_data); end
    reset = 1'b0;
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b required 1", cmd_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b required 0", busy); end
    $display("reset: held 3 cycles, released");
  endtask

  task automatic test_single;
    clear_logs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd3; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (wdata_ready !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL single_wr_state: got wdata_ready=%b busy=%b required 1 1", wdata_ready, busy); end
    wdata_valid = 1'b1; wdata = 8'hA5;
    #1;
    n_checks++; if ({rf_load, rf_load_addr, rf_data_in} !== {1'b1, 4'd3, 8'hA5}) begin n_fail++; $display("FAIL single_rf_load: got %b/%h/%h required 1/3/a5", rf_load, rf_load_addr, rf_data_in); end
    tick();
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_wr_done: got done=%b cmd_ready=%b required 1 1", done, cmd_ready); end
    n_checks++; if (load_addr_q.size() != 1) begin n_fail++; $display("FAIL single_load_count: got %0d required 1", load_addr_q.size()); end
    $display("write addr=3 len=0 data=a5");
    tick();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %b required 0", done); end

    store_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd3; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (rf_store !== 1'b1 || rf_store_addr !== 4'd3) begin n_fail++; $display("FAIL single_rf_store: got %b/%h required 1/3", rf_store, rf_store_addr); end
    tick();
    n_checks++; if (rf_store !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_capture: got store=%b rsp_valid=%b required 0 0", rf_store, rsp_valid); end
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'hA5) begin n_fail++; $display("FAIL single_rsp: got valid=%b data=%h required 1 a5", rsp_valid, rsp_data); end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++; if (done !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rd_done: got done=%b rsp_valid=%b required 1 0", done, rsp_valid); end
    n_checks++; if (store_cnt != 1) begin n_fail++; $display("FAIL single_store_count: got %0d required 1", store_cnt); end
    $display("read addr=3 len=0 data=%h", rsp_data);
    tick();
  endtask

  task automatic test_burst_write;
    int d0;
    logic [3:0] ea;
    logic [7:0] ed;
    clear_logs();
    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin
        wdata_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          #1;
          n_checks++; if (rf_load !== 1'b0) begin n_fail++; $display("FAIL burst_wr_gap: got rf_load=%b required 0", rf_load); end
          tick();
        end
      end
      wdata_valid = 1'b1; wdata = 8'(i + 1);
      tick();
    end
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL burst_wr_done: got %b required 1", done); end
    tick();
    n_checks++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL burst_wr_done_count: got %0d required 1", done_cnt - d0); end
    n_checks++; if (load_addr_q.size() != 4) begin n_fail++; $display("FAIL burst_wr_load_count: got %0d required 4", load_addr_q.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        ea = 4'(14 + i);
        ed = 8'(i + 1);
        n_checks++; if (load_addr_q[i] !== ea || load_data_q[i] !== ed) begin n_fail++; $display("FAIL burst_wr_beat%0d: got %h/%h required %h/%h", i, load_addr_q[i], load_data_q[i], ea, ed); end
      end
    end
    $display("write addr=14 len=3 data=01,02,03,04 with gap");
  endtask

  task automatic test_burst_read;
    int s0;
    logic [7:0] ed;
    store_cnt = 0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      tick(); tick();
      ed = 8'(b + 1);
      n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== ed) begin n_fail++; $display("FAIL burst_rd_beat%0d: got valid=%b data=%h required 1 %h", b, rsp_valid, rsp_data, ed); end
      if (b == 2) begin
        s0 = store_cnt;
        for (int w = 0; w < 5; w++) begin
          tick();
          n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rf_store !== 1'b0) begin n_fail++; $display("FAIL burst_rd_hold: got valid=%b data=%h store=%b required 1 03 0", rsp_valid, rsp_data, rf_store); end
        end
        n_checks++; if (store_cnt != s0) begin n_fail++; $display("FAIL burst_rd_hold_stores: got %0d required %0d", store_cnt, s0); end
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
    end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL burst_rd_done: got %b required 1", done); end
    n_checks++; if (store_cnt != 4) begin n_fail++; $display("FAIL burst_rd_store_count: got %0d required 4", store_cnt); end
    $display("read addr=14 len=3 data=01,02,03,04 with 5-cycle stall");
    tick();
  endtask

  task automatic test_reset_mid;
    int d0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 4'd14; cmd_len = 4'd3;
    tick();
    cmd_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      tick(); tick();
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    end
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h03) begin n_fail++; $display("FAIL mid_pre_reset: got valid=%b data=%h required 1 03", rsp_valid, rsp_data); end
    d0 = done_cnt;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset: got ready=%b busy=%b rsp_valid=%b required 1 0 0", cmd_ready, busy, rsp_valid); end
    n_checks++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL mid_rsp_data_cleared: got %h required 00", rsp_data); end
    tick();
    n_checks++; if (done !== 1'b0 || done_cnt != d0) begin n_fail++; $display("FAIL mid_no_done: got done=%b pulses=%0d required 0 0", done, done_cnt - d0); end
    clear_logs();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd5; cmd_len = 4'd0;
    tick();
    cmd_valid = 1'b0; wdata_valid = 1'b1; wdata = 8'h3C;
    tick();
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || load_addr_q.size() != 1) begin n_fail++; $display("FAIL mid_new_cmd: got done=%b loads=%0d required 1 1", done, load_addr_q.size()); end
    $display("reset in read hold beat 2, then write addr=5 data=3c");
    tick();
  endtask

  task automatic test_back_to_back;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd8; cmd_len = 4'd1;
    tick();
    cmd_write = 1'b0; cmd_addr = 4'd9; cmd_len = 4'd0;
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_beat0: got %b required 0", cmd_ready); end
    wdata_valid = 1'b1; wdata = 8'h11;
    tick();
    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_beat1: got %b required 0", cmd_ready); end
    wdata = 8'h22;
    tick();
    wdata_valid = 1'b0;
    n_checks++; if (done !== 1'b1 || cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_done_ready: got done=%b ready=%b required 1 1", done, cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    n_checks++; if (rf_store !== 1'b1 || rf_store_addr !== 4'd9) begin n_fail++; $display("FAIL b2b_second_cmd: got store=%b addr=%h required 1 9", rf_store, rf_store_addr); end
    tick(); tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_data !== 8'h22) begin n_fail++; $display("FAIL b2b_rsp: got valid=%b data=%h required 1 22", rsp_valid, rsp_data); end
    rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_done: got %b required 1", done); end
    $display("write addr=8 len=1 then read addr=9 with cmd_valid held");
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rf_data_out = 8'h00;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 4'd0; cmd_len = 4'd0;
    wdata_valid = 1'b0; wdata = 8'h00; rsp_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
    test_reset();
    test_single();
    test_burst_write();
    test_burst_read();
    test_reset_mid();
    test_back_to_back();
    n_checks++; if (overlap_cnt != 0) begin n_fail++; $display("FAIL load_store_overlap: got %0d cycles required 0", overlap_cnt); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
